// File: rtl/vga_csm_defs.sv
// Shared constants for the vga_csm_nport memory arbiter: port-count limits
// and the port-index width helper used by the top and the arbiter.
package vga_csm_defs;

    localparam int NPORTS_MIN = 2;
    localparam int NPORTS_MAX = 8;

    // Port index width; a two-port build still needs a one-bit index.
    function automatic int port_idx_w(input int nports);
        int w;
        w = $clog2(nports);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

    function automatic bit nports_legal(input int nports);
        return (nports >= NPORTS_MIN) && (nports <= NPORTS_MAX);
    endfunction

endpackage

// File: rtl/generic_spram.sv
// Generic single-port synchronous RAM: write on clock when ce&we, read data
// registered from the applied address; contents are never reset.
module generic_spram #(
    parameter int aw = 8,
    parameter int dw = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce,
    input  logic          we,
    input  logic          oe,
    input  logic [aw-1:0] addr,
    input  logic [dw-1:0] di,
    output logic [dw-1:0] dout
);

    logic [dw-1:0] mem [0:(2**aw)-1];
    logic [dw-1:0] dout_reg;

    always_ff @(posedge clk) begin
        if (ce && we) begin
            mem[addr] <= di;
        end
    end

    // Read happens every enabled cycle; the requester-side logic decides
    // which cycle's data is meaningful.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_reg <= '0;
        end else if (ce) begin
            dout_reg <= mem[addr];
        end
    end

    assign dout = oe ? dout_reg : '0;

endmodule

// File: rtl/vga_csm_arb.sv
// One-of-N grant arbiter over the eligible mask. With VGA_CSM_RR_EN defined the
// search rotates from the last grant; otherwise the lowest index wins.
module vga_csm_arb
    import vga_csm_defs::*;
#(
    parameter int NPORTS = 4,
    parameter int IW     = port_idx_w(NPORTS)
) (
`ifdef VGA_CSM_RR_EN
    input  logic              clk,
`endif
    input  logic              srst,
    input  logic [NPORTS-1:0] eligible,
    output logic [NPORTS-1:0] gnt,
    output logic [IW-1:0]     gnt_idx,
    output logic              gnt_valid
);

    logic [NPORTS-1:0] elig_masked;

    assign elig_masked = srst ? '0 : eligible;

`ifdef VGA_CSM_RR_EN
    logic [IW-1:0] last_grant_reg;

    // Pick the eligible port closest after last_grant in circular order.
    always_comb begin
        int best_dist;
        int dist;
        best_dist = NPORTS;
        dist      = 0;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int p = 0; p < NPORTS; p++) begin
            dist = (p - int'(last_grant_reg) - 1 + 2 * NPORTS) % NPORTS;
            if (elig_masked[p] && (dist < best_dist)) begin
                best_dist = dist;
                gnt_valid = 1'b1;
                gnt_idx   = IW'(p);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            last_grant_reg <= IW'(NPORTS - 1);
        end else if (gnt_valid) begin
            last_grant_reg <= gnt_idx;
        end
    end
`else
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int p = NPORTS - 1; p >= 0; p--) begin
            if (elig_masked[p]) begin
                gnt_valid = 1'b1;
                gnt_idx   = IW'(p);
            end
        end
    end
`endif

    generate
        for (genvar gi = 0; gi < NPORTS; gi++) begin : g_onehot
            assign gnt[gi] = gnt_valid && (gnt_idx == IW'(gi));
        end
    endgenerate

endmodule

// File: rtl/vga_csm_nport.sv
// N-port shared memory with one access per cycle: writes ack in the grant
// cycle, reads ack one cycle later. VGA_CSM_RR_EN selects round-robin priority.
module vga_csm_nport
    import vga_csm_defs::*;
#(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 8,
    parameter int NPORTS = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NPORTS-1:0]        req_i,
    input  logic [NPORTS-1:0]        we_i,
    input  logic [NPORTS*AWIDTH-1:0] adr_i,
    input  logic [NPORTS*DWIDTH-1:0] dat_i,
    output logic [NPORTS-1:0]        ack_o,
    output logic [DWIDTH-1:0]        dat_o
);

    localparam int IW = port_idx_w(NPORTS);

    logic [NPORTS-1:0] eligible;
    logic [NPORTS-1:0] gnt;
    logic [IW-1:0]     gnt_idx;
    logic              gnt_valid;
    logic [NPORTS-1:0] wr_ack;
    logic [NPORTS-1:0] rd_ack;

    logic              rd_pend_reg;
    logic [IW-1:0]     rd_port_reg;

    logic              mem_we;
    logic [AWIDTH-1:0] mem_adr;
    logic [DWIDTH-1:0] mem_di;
    logic [DWIDTH-1:0] mem_do;

    // A port waiting on its read ack sits out this cycle's arbitration.
    generate
        for (genvar gi = 0; gi < NPORTS; gi++) begin : g_port
            assign eligible[gi] = req_i[gi] && !(rd_pend_reg && (rd_port_reg == IW'(gi)));
            assign rd_ack[gi]   = !rst_i && rd_pend_reg && (rd_port_reg == IW'(gi));
            assign wr_ack[gi]   = gnt[gi] && we_i[gi];
        end
    endgenerate

    vga_csm_arb #(
        .NPORTS (NPORTS),
        .IW     (IW)
    ) u_arb (
`ifdef VGA_CSM_RR_EN
        .clk       (clk_i),
`endif
        .srst      (rst_i),
        .eligible  (eligible),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    // One-hot grant steers the winning port onto the memory port.
    always_comb begin
        mem_we  = 1'b0;
        mem_adr = '0;
        mem_di  = '0;
        for (int p = 0; p < NPORTS; p++) begin
            if (gnt[p]) begin
                mem_we  = we_i[p];
                mem_adr = adr_i[p*AWIDTH +: AWIDTH];
                mem_di  = dat_i[p*DWIDTH +: DWIDTH];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_pend_reg <= 1'b0;
            rd_port_reg <= '0;
        end else begin
            rd_pend_reg <= gnt_valid && !mem_we;
            if (gnt_valid && !mem_we) begin
                rd_port_reg <= gnt_idx;
            end
        end
    end

    generic_spram #(
        .aw (AWIDTH),
        .dw (DWIDTH)
    ) u_ram (
        .clk  (clk_i),
        .rst  (1'b0),
        .ce   (1'b1),
        .we   (mem_we),
        .oe   (1'b1),
        .addr (mem_adr),
        .di   (mem_di),
        .dout (mem_do)
    );

    assign ack_o = wr_ack | rd_ack;
    assign dat_o = mem_do;

endmodule

// File: tb/tb_vga_csm_nport.sv
// Directed bench for vga_csm_nport (4 ports); arbitration expectations follow
// whether VGA_CSM_RR_EN is defined for the build.
module tb_vga_csm_nport;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req;
    logic [N-1:0]  we;
    logic [N*AW-1:0] adr;
    logic [N*DW-1:0] dat;
    logic [N-1:0]  ack;
    logic [DW-1:0] dat_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vga_csm_nport #(
        .DWIDTH (DW),
        .AWIDTH (AW),
        .NPORTS (N)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .req_i (req),
        .we_i  (we),
        .adr_i (adr),
        .dat_i (dat),
        .ack_o (ack),
        .dat_o (dat_o)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        req = '0;
        we  = '0;
    endtask

    task automatic set_port(input int p, input logic r, input logic w,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[p]          = r;
        we[p]           = w;
        adr[p*AW +: AW] = a;
        dat[p*DW +: DW] = d;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_all();
        adr = '0;
        dat = '0;
        set_port(0, 1'b1, 1'b1, 8'h40, 32'h1111_1111);
        step();
        @(negedge clk);
        checks++;
        if (ack !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ack0 ack=%b expected=%b", ack, 4'b0000);
        end
        set_port(1, 1'b1, 1'b0, 8'h40, 32'h0);
        step();
        @(negedge clk);
        checks++;
        if (ack !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ack1 ack=%b expected=%b", ack, 4'b0000);
        end
        $display("txn reset ack=%b", ack);
        idle_all();
    endtask

    task automatic test_write_read();
        step();
        rst = 1'b0;
        idle_all();
        set_port(2, 1'b1, 1'b1, 8'h10, 32'hDEAD_BEEF);
        @(negedge clk);
        checks++;
        if (ack !== 4'b0100) begin
            failures++;
            $display("FAIL write_ack ack=%b expected=%b", ack, 4'b0100);
        end
        $display("txn write p2 adr=10 ack=%b", ack);
        step();
        idle_all();
        set_port(1, 1'b1, 1'b0, 8'h10, 32'h0);
        @(negedge clk);
        checks++;
        if (ack !== 4'b0000) begin
            failures++;
            $display("FAIL read_grant_ack ack=%b expected=%b", ack, 4'b0000);
        end
        step();
        @(negedge clk);
        checks++;
        if (ack !== 4'b0010) begin
            failures++;
            $display("FAIL read_ack ack=%b expected=%b", ack, 4'b0010);
        end
        checks++;
        if (dat_o !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL read_data dat=%h expected=%h", dat_o, 32'hDEAD_BEEF);
        end
        $display("txn read p1 adr=10 ack=%b dat=%h", ack, dat_o);
        step();
        idle_all();
        @(negedge clk);
        checks++;
        if (ack !== 4'b0000) begin
            failures++;
            $display("FAIL idle_ack ack=%b expected=%b", ack, 4'b0000);
        end
    endtask

    task automatic preload();
        logic [3:0] exp;
        for (int p = 0; p < N; p++) begin
            step();
            idle_all();
            set_port(p, 1'b1, 1'b1, AW'(8'h30 + p), 32'hA000_0000 + p);
            exp = 4'b0001 << p;
            @(negedge clk);
            checks++;
            if (ack !== exp) begin
                failures++;
                $display("FAIL preload_ack p=%0d ack=%b expected=%b", p, ack, exp);
            end
            $display("txn write p%0d ack=%b", p, ack);
        end
        step();
        idle_all();
    endtask

    task automatic reset_pulse();
        step();
        idle_all();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_all_ports_rotation();
        int exp_port [5];
        logic [3:0] exp_ack;
`ifdef VGA_CSM_RR_EN
        exp_port = '{0, 1, 2, 3, 0};
`else
        exp_port = '{0, 1, 0, 1, 0};
`endif
        preload();
        reset_pulse();
        for (int p = 0; p < N; p++) begin
            set_port(p, 1'b1, 1'b0, AW'(8'h30 + p), 32'h0);
        end
        @(negedge clk);
        checks++;
        if (ack !== 4'b0000) begin
            failures++;
            $display("FAIL rot_first ack=%b expected=%b", ack, 4'b0000);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            @(negedge clk);
            exp_ack = 4'b0001 << exp_port[i];
            checks++;
            if (ack !== exp_ack) begin
                failures++;
                $display("FAIL rot_ack i=%0d ack=%b expected=%b", i, ack, exp_ack);
            end
            checks++;
            if (dat_o !== 32'hA000_0000 + exp_port[i]) begin
                failures++;
                $display("FAIL rot_data i=%0d dat=%h expected=%h", i, dat_o,
                         32'hA000_0000 + exp_port[i]);
            end
            $display("txn rot read i=%0d ack=%b dat=%h", i, ack, dat_o);
        end
        step();
        idle_all();
        step();
    endtask

    task automatic test_pair_0_3();
        logic [3:0] exp_seq [4];
        exp_seq = '{4'b0000, 4'b0001, 4'b1000, 4'b0001};
        reset_pulse();
        set_port(0, 1'b1, 1'b0, 8'h30, 32'h0);
        set_port(3, 1'b1, 1'b0, 8'h33, 32'h0);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            @(negedge clk);
            checks++;
            if (ack !== exp_seq[i]) begin
                failures++;
                $display("FAIL pair_ack i=%0d ack=%b expected=%b", i, ack, exp_seq[i]);
            end
            if (i > 0) begin
                checks++;
                if (dat_o !== ((exp_seq[i] == 4'b0001) ? 32'hA000_0000 : 32'hA000_0003)) begin
                    failures++;
                    $display("FAIL pair_data i=%0d dat=%h", i, dat_o);
                end
            end
            $display("txn pair i=%0d ack=%b dat=%h", i, ack, dat_o);
        end
        step();
        idle_all();
        step();
    endtask

    task automatic test_reset_during_read();
        step();
        idle_all();
        set_port(0, 1'b1, 1'b0, 8'h30, 32'h0);
        @(negedge clk);
        step();
        rst = 1'b1;
        set_port(1, 1'b1, 1'b0, 8'h31, 32'h0);
        @(negedge clk);
        checks++;
        if (ack !== 4'b0000) begin
            failures++;
            $display("FAIL rst_read_ack ack=%b expected=%b", ack, 4'b0000);
        end
        step();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (ack !== 4'b0000) begin
            failures++;
            $display("FAIL rst_release_ack ack=%b expected=%b", ack, 4'b0000);
        end
        step();
        @(negedge clk);
        checks++;
        if (ack !== 4'b0001 || dat_o !== 32'hA000_0000) begin
            failures++;
            $display("FAIL rst_first_grant ack=%b dat=%h expected=0001/a0000000", ack, dat_o);
        end
        $display("txn post-reset read p0 ack=%b dat=%h", ack, dat_o);
        step();
        idle_all();
        @(negedge clk);
        checks++;
        if (ack !== 4'b0010 || dat_o !== 32'hA000_0001) begin
            failures++;
            $display("FAIL rst_second_grant ack=%b dat=%h expected=0010/a0000001", ack, dat_o);
        end
        step();
    endtask

    task automatic test_back_to_back();
        step();
        idle_all();
        set_port(3, 1'b1, 1'b1, 8'h20, 32'h0000_005A);
        @(negedge clk);
        checks++;
        if (ack !== 4'b1000) begin
            failures++;
            $display("FAIL b2b_write_ack ack=%b expected=%b", ack, 4'b1000);
        end
        step();
        idle_all();
        set_port(0, 1'b1, 1'b0, 8'h20, 32'h0);
        @(negedge clk);
        checks++;
        if (ack !== 4'b0000) begin
            failures++;
            $display("FAIL b2b_grant_ack ack=%b expected=%b", ack, 4'b0000);
        end
        step();
        set_port(2, 1'b1, 1'b1, 8'h21, 32'h0000_0077);
        @(negedge clk);
        checks++;
        if (ack !== 4'b0101) begin
            failures++;
            $display("FAIL b2b_overlap_ack ack=%b expected=%b", ack, 4'b0101);
        end
        checks++;
        if (dat_o !== 32'h0000_005A) begin
            failures++;
            $display("FAIL b2b_data dat=%h expected=%h", dat_o, 32'h0000_005A);
        end
        $display("txn b2b read p0 + write p2 ack=%b dat=%h", ack, dat_o);
        step();
        idle_all();
        set_port(1, 1'b1, 1'b0, 8'h21, 32'h0);
        step();
        @(negedge clk);
        checks++;
        if (ack !== 4'b0010 || dat_o !== 32'h0000_0077) begin
            failures++;
            $display("FAIL b2b_readback ack=%b dat=%h expected=0010/00000077", ack, dat_o);
        end
        $display("txn readback p1 adr=21 ack=%b dat=%h", ack, dat_o);
        step();
        idle_all();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_all_ports_rotation();
        test_pair_0_3();
        test_reset_during_read();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
